// File: rtl/sbp_pkg.sv
// Shared types and field layout for the trie-lookup stage pipeline.
// Struct widths follow the package localparams; stage parameters must match them.
package sbp_pkg;

    localparam int SBP_IP_BITS     = 32;
    localparam int SBP_ADDR_BITS   = 11;
    localparam int SBP_RESULT_BITS = 16;
    localparam int SBP_DATA_BITS   = 64;
    localparam int SBP_BP_BITS     = $clog2(SBP_IP_BITS) + 1;

    localparam int SBP_CHILD0_BIT  = SBP_ADDR_BITS;
    localparam int SBP_CHILD1_BIT  = SBP_ADDR_BITS + 1;
    localparam int SBP_PREFIX_BIT  = SBP_ADDR_BITS + 2;
    localparam int SBP_RESULT_LSB  = SBP_ADDR_BITS + 3;
    localparam int SBP_NODE_BITS   = SBP_RESULT_LSB + SBP_RESULT_BITS;

    typedef struct packed {
        logic [SBP_RESULT_BITS-1:0] result;
        logic                       prefix_vld;
        logic                       child1_vld;
        logic                       child0_vld;
        logic [SBP_ADDR_BITS-1:0]   child_base;
    } sbp_node_t;

    typedef struct packed {
        logic                       valid;
        logic                       active;
        logic [SBP_IP_BITS-1:0]     ip_addr;
        logic [SBP_BP_BITS-1:0]     bit_pos;
        logic [SBP_ADDR_BITS-1:0]   location;
        logic [SBP_RESULT_BITS-1:0] result;
        logic                       result_vld;
    } sbp_lookup_t;

    function automatic sbp_node_t sbp_unpack_node(input logic [SBP_NODE_BITS-1:0] w);
        sbp_node_t n;
        n.child_base = w[SBP_ADDR_BITS-1:0];
        n.child0_vld = w[SBP_CHILD0_BIT];
        n.child1_vld = w[SBP_CHILD1_BIT];
        n.prefix_vld = w[SBP_PREFIX_BIT];
        n.result     = w[SBP_RESULT_LSB +: SBP_RESULT_BITS];
        return n;
    endfunction

    // Key bit at MSB-relative position bp; out-of-range positions read as 0.
    function automatic logic sbp_key_bit(input logic [SBP_IP_BITS-1:0] ip,
                                         input logic [SBP_BP_BITS-1:0] bp);
        logic [SBP_IP_BITS-1:0] sh;
        sh = ip << bp;
        return sh[SBP_IP_BITS-1];
    endfunction

endpackage

// File: rtl/bram_tdp.sv
// True dual-port block RAM, one registered read per port, no content reset.
module bram_tdp #(
    parameter int    DATA_W    = 64,
    parameter int    ADDR_W    = 11,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              a_en_i,
    input  logic              a_we_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [DATA_W-1:0] a_din_i,
    output logic [DATA_W-1:0] a_dout_o,
    input  logic              b_en_i,
    input  logic              b_we_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [DATA_W-1:0] b_din_i,
    output logic [DATA_W-1:0] b_dout_o
);

    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];

    // Image preload is attached by the implementation flow's memory-init
    // mechanism keyed on INIT_FILE; without it the array starts undefined.
    if (INIT_FILE != "") begin : g_init_file
    end

    // Read-first on both ports; port B wins a same-address double write.
    always_ff @(posedge clk) begin
        if (a_en_i) begin
            if (a_we_i) mem_q[a_addr_i] <= a_din_i;
            a_dout_o <= mem_q[a_addr_i];
        end
        if (b_en_i) begin
            if (b_we_i) mem_q[b_addr_i] <= b_din_i;
            b_dout_o <= mem_q[b_addr_i];
        end
    end

endmodule

// File: rtl/sbp_lookup_stage_pipe.sv
// One trie-lookup stage: S0 issues the node read, S1 receives data, S2 decodes.
// Control-plane writes on port B are forwarded into in-flight reads.
module sbp_lookup_stage_pipe
    import sbp_pkg::*;
#(
    parameter int    STAGE_ID    = 0,
    parameter int    IP_BITS     = SBP_IP_BITS,
    parameter int    ADDR_BITS   = SBP_ADDR_BITS,
    parameter int    RESULT_BITS = SBP_RESULT_BITS,
    parameter int    DATA_BITS   = SBP_DATA_BITS,
    parameter string MEMINITFILE = ""
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       valid_i,
    input  logic                       active_i,
    input  logic [IP_BITS-1:0]         ip_addr_i,
    input  logic [$clog2(IP_BITS):0]   bit_pos_i,
    input  logic [ADDR_BITS-1:0]       location_i,
    input  logic [RESULT_BITS-1:0]     result_i,
    input  logic                       result_vld_i,
    output logic                       valid_o,
    output logic                       active_o,
    output logic [IP_BITS-1:0]         ip_addr_o,
    output logic [$clog2(IP_BITS):0]   bit_pos_o,
    output logic [ADDR_BITS-1:0]       location_o,
    output logic [RESULT_BITS-1:0]     result_o,
    output logic                       result_vld_o,
    input  logic                       wr_en_i,
    input  logic [ADDR_BITS-1:0]       wr_addr_i,
    input  logic [DATA_BITS-1:0]       wr_data_i,
    output logic [31:0]                stat_lookups_o
);

    localparam int BP_BITS = $clog2(IP_BITS) + 1;

    if (DATA_BITS < ADDR_BITS + 3 + RESULT_BITS || IP_BITS != SBP_IP_BITS ||
        ADDR_BITS != SBP_ADDR_BITS || RESULT_BITS != SBP_RESULT_BITS || STAGE_ID < 0)
    begin : g_bad_params
        $error("sbp_lookup_stage_pipe: parameters inconsistent with sbp_pkg node layout");
    end

    sbp_lookup_t          in_w, s1_q, out_d, out_q;
    sbp_node_t            node;
    logic                 rd_en, wr_en;
    logic                 fwd_vld_q;
    logic [DATA_BITS-1:0] fwd_data_q;
    logic [DATA_BITS-1:0] rd_data, node_word, bram_b_unused;
    logic                 key_b, child_ok;
    logic [31:0]          stat_q;

    assign in_w.valid      = valid_i;
    assign in_w.active     = active_i;
    assign in_w.ip_addr    = ip_addr_i;
    assign in_w.bit_pos    = bit_pos_i;
    assign in_w.location   = location_i;
    assign in_w.result     = result_i;
    assign in_w.result_vld = result_vld_i;

    // Terminated lookups never touch memory; writes during reset are dropped.
    assign rd_en = valid_i & active_i;
    assign wr_en = wr_en_i & rst_n;

    bram_tdp #(
        .DATA_W   (DATA_BITS),
        .ADDR_W   (ADDR_BITS),
        .INIT_FILE(MEMINITFILE)
    ) u_bram (
        .clk     (clk),
        .a_en_i  (rd_en),
        .a_we_i  (1'b0),
        .a_addr_i(location_i),
        .a_din_i ('0),
        .a_dout_o(rd_data),
        .b_en_i  (wr_en),
        .b_we_i  (wr_en),
        .b_addr_i(wr_addr_i),
        .b_din_i (wr_data_i),
        .b_dout_o(bram_b_unused)
    );

    // S0 write hit is captured here because the BRAM reads old data on a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q       <= '0;
            fwd_vld_q  <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            s1_q      <= in_w;
            fwd_vld_q <= wr_en && (wr_addr_i == location_i);
            if (wr_en && (wr_addr_i == location_i)) fwd_data_q <= wr_data_i;
        end
    end

    // The S1 write is the youngest, so it overrides a captured S0 hit.
    always_comb begin
        node_word = rd_data;
        if (wr_en && (wr_addr_i == s1_q.location)) node_word = wr_data_i;
        else if (fwd_vld_q)                        node_word = fwd_data_q;
    end

    if (DATA_BITS > SBP_NODE_BITS) begin : g_hi_sink
        logic [DATA_BITS-SBP_NODE_BITS-1:0] node_hi_unused;
        assign node_hi_unused = node_word[DATA_BITS-1:SBP_NODE_BITS];
    end

    always_comb begin
        out_d    = s1_q;
        node     = sbp_unpack_node(node_word[SBP_NODE_BITS-1:0]);
        key_b    = sbp_key_bit(s1_q.ip_addr, s1_q.bit_pos);
        child_ok = 1'b0;
        if (s1_q.valid && s1_q.active) begin
            child_ok = (s1_q.bit_pos < BP_BITS'(IP_BITS)) &&
                       (key_b ? node.child1_vld : node.child0_vld);
            if (node.prefix_vld) begin
                out_d.result     = node.result;
                out_d.result_vld = 1'b1;
            end
            out_d.bit_pos  = s1_q.bit_pos + 1'b1;
            out_d.active   = child_ok;
            out_d.location = child_ok ? node.child_base + SBP_ADDR_BITS'(key_b) : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            stat_q <= '0;
        end else begin
            out_q <= out_d;
            if (rd_en && (stat_q != '1)) stat_q <= stat_q + 32'd1;
        end
    end

    assign valid_o        = out_q.valid;
    assign active_o       = out_q.active;
    assign ip_addr_o      = out_q.ip_addr;
    assign bit_pos_o      = out_q.bit_pos;
    assign location_o     = out_q.location;
    assign result_o       = out_q.result;
    assign result_vld_o   = out_q.result_vld;
    assign stat_lookups_o = stat_q;

endmodule

// File: tb/tb_sbp_lookup_stage_pipe.sv
// Directed bench: vector table for single-lookup decode, hand sequences for
// forwarding, streaming and reset during traffic.
module tb_sbp_lookup_stage_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i, active_i, result_vld_i, wr_en_i;
    logic [31:0] ip_addr_i;
    logic [5:0]  bit_pos_i;
    logic [10:0] location_i, wr_addr_i;
    logic [15:0] result_i;
    logic [63:0] wr_data_i;
    logic        valid_o, active_o, result_vld_o;
    logic [31:0] ip_addr_o, stat_lookups_o;
    logic [5:0]  bit_pos_o;
    logic [10:0] location_o;
    logic [15:0] result_o;

    int checks = 0;
    int errors = 0;
    int exp_stat = 0;

    always #5 clk = ~clk;

    sbp_lookup_stage_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .valid_i(valid_i), .active_i(active_i), .ip_addr_i(ip_addr_i),
        .bit_pos_i(bit_pos_i), .location_i(location_i), .result_i(result_i),
        .result_vld_i(result_vld_i),
        .valid_o(valid_o), .active_o(active_o), .ip_addr_o(ip_addr_o),
        .bit_pos_o(bit_pos_o), .location_o(location_o), .result_o(result_o),
        .result_vld_o(result_vld_o),
        .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .stat_lookups_o(stat_lookups_o)
    );

    typedef struct {
        logic        act;
        logic [31:0] ip;
        logic [5:0]  bp;
        logic [10:0] loc;
        logic [15:0] res;
        logic        rv;
        logic        e_act;
        logic [10:0] e_loc;
        logic [15:0] e_res;
        logic        e_rv;
        logic [5:0]  e_bp;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [63:0] mk_node(input logic [10:0] base, input logic c0,
                                            input logic c1, input logic pv,
                                            input logic [15:0] res);
        return {34'd0, res, pv, c1, c0, base};
    endfunction

    function automatic vec_t mkv(input logic act, input logic [31:0] ip, input logic [5:0] bp,
                                 input logic [10:0] loc, input logic [15:0] res, input logic rv,
                                 input logic e_act, input logic [10:0] e_loc,
                                 input logic [15:0] e_res, input logic e_rv, input logic [5:0] e_bp);
        vec_t v;
        v.act = act; v.ip = ip; v.bp = bp; v.loc = loc; v.res = res; v.rv = rv;
        v.e_act = e_act; v.e_loc = e_loc; v.e_res = e_res; v.e_rv = e_rv; v.e_bp = e_bp;
        return v;
    endfunction

    task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic a, input logic [31:0] ip,
                         input logic [5:0] bp, input logic [10:0] loc,
                         input logic [15:0] res, input logic rv);
        valid_i = v; active_i = a; ip_addr_i = ip; bit_pos_i = bp;
        location_i = loc; result_i = res; result_vld_i = rv;
    endtask

    task automatic write_node(input logic [10:0] a, input logic [63:0] d);
        @(negedge clk);
        wr_en_i = 1'b1; wr_addr_i = a; wr_data_i = d;
        @(negedge clk);
        wr_en_i = 1'b0;
    endtask

    // Lookup at node 3 (old result 0x11); write A hits node 3 at offset ca,
    // write B hits baddr at offset cb (offset 0 = issue cycle, -1 = none).
    task automatic fwd_case(input string nm, input int ca, input logic [15:0] ares,
                            input int cb, input logic [10:0] baddr, input logic [15:0] bres,
                            input logic [15:0] exp_res);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            drive(c == 0, 1'b1, 32'h0, 6'd0, 11'd3, 16'h0, 1'b0);
            wr_en_i = 1'b0;
            if (c == ca) begin wr_en_i = 1'b1; wr_addr_i = 11'd3; wr_data_i = mk_node(0, 0, 0, 1, ares); end
            if (c == cb) begin wr_en_i = 1'b1; wr_addr_i = baddr; wr_data_i = mk_node(0, 0, 0, 1, bres); end
        end
        @(posedge clk); #1;
        check(nm, {valid_o, result_vld_o, result_o}, {1'b1, 1'b1, exp_res});
        @(negedge clk);
        wr_en_i = 1'b0;
        if (ca == 2) begin wr_en_i = 1'b1; wr_addr_i = 11'd3; wr_data_i = mk_node(0, 0, 0, 1, ares); end
        @(negedge clk);
        wr_en_i = 1'b0;
        write_node(11'd3, mk_node(0, 0, 0, 1, 16'h0011));
    endtask

    initial begin
        vecs[0] = mkv(1, 32'h80000000, 0,  5, 16'h0000, 0,  1, 11'h021, 16'h0042, 1, 1);
        vecs[1] = mkv(1, 32'h80000000, 0,  6, 16'h0000, 0,  0, 11'h000, 16'h0042, 1, 1);
        vecs[2] = mkv(0, 32'h12345678, 9,  5, 16'h0007, 1,  0, 11'h005, 16'h0007, 1, 9);
        vecs[3] = mkv(1, 32'hFFFFFFFF, 31, 7, 16'h0033, 1,  1, 11'h000, 16'h0033, 1, 32);
        vecs[4] = mkv(1, 32'h40000000, 0,  7, 16'h0000, 0,  1, 11'h7FF, 16'h0000, 0, 1);
        vecs[5] = mkv(1, 32'hFFFFFFFF, 32, 5, 16'h0000, 0,  0, 11'h000, 16'h0042, 1, 33);
        vecs[6] = mkv(1, 32'h00000000, 3,  8, 16'h0055, 0,  1, 11'h010, 16'h0055, 0, 4);
        vecs[7] = mkv(1, 32'h10000000, 3,  8, 16'h0055, 0,  0, 11'h000, 16'h0055, 0, 4);

        rst_n = 1'b0;
        wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("reset_outputs", {valid_o, active_o, result_vld_o, ip_addr_o, bit_pos_o, location_o, result_o}, '0);
        check("reset_stat", stat_lookups_o, 0);
        rst_n = 1'b1;

        write_node(11'd3, mk_node(11'h000, 0, 0, 1, 16'h0011));
        write_node(11'd5, mk_node(11'h020, 1, 1, 1, 16'h0042));
        write_node(11'd6, mk_node(11'h020, 1, 0, 1, 16'h0042));
        write_node(11'd7, mk_node(11'h7FF, 1, 1, 0, 16'h0099));
        write_node(11'd8, mk_node(11'h010, 1, 0, 0, 16'h0011));

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(1'b1, vecs[i].act, vecs[i].ip, vecs[i].bp, vecs[i].loc, vecs[i].res, vecs[i].rv);
            @(negedge clk);
            valid_i = 1'b0;
            @(posedge clk); #1;
            if (vecs[i].act) exp_stat++;
            check($sformatf("vec%0d", i),
                  {valid_o, active_o, location_o, result_o, result_vld_o, bit_pos_o, ip_addr_o},
                  {1'b1, vecs[i].e_act, vecs[i].e_loc, vecs[i].e_res, vecs[i].e_rv, vecs[i].e_bp, vecs[i].ip});
            check($sformatf("vec%0d_stat", i), stat_lookups_o, 32'(exp_stat));
        end

        fwd_case("fwd_s0",    0, 16'h00AA, -1, 11'd0, 16'h0000, 16'h00AA);
        fwd_case("fwd_s1",    1, 16'h00AA, -1, 11'd0, 16'h0000, 16'h00AA);
        fwd_case("fwd_late",  2, 16'h00AA, -1, 11'd0, 16'h0000, 16'h0011);
        fwd_case("fwd_young", 0, 16'h00AA,  1, 11'd3, 16'h00BB, 16'h00BB);
        fwd_case("fwd_other", 0, 16'h00AA,  1, 11'd4, 16'h00BB, 16'h00AA);
        fwd_case("fwd_none", -1, 16'h00AA, -1, 11'd0, 16'h0000, 16'h0011);

        for (int i = 0; i < 64; i++) write_node(11'(i), mk_node(11'(i), 0, 0, 1, 16'h0100 + 16'(i)));
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        for (int c = 0; c <= 64; c++) begin
            @(negedge clk);
            if (c < 64) drive(1'b1, 1'b1, 32'h0, 6'd0, 11'(c), 16'h0, 1'b0);
            else        drive(0, 0, 0, 0, 0, 0, 0);
            @(posedge clk); #1;
            if (c >= 1)
                check($sformatf("stream%0d", c - 1), {valid_o, active_o, result_vld_o, result_o},
                      {1'b1, 1'b0, 1'b1, 16'h0100 + 16'(c - 1)});
        end
        @(posedge clk); #1;
        check("stream_end_valid", valid_o, 1'b0);
        check("stream_stat", stat_lookups_o, 32'd64);

        // Reset with two lookups in flight and a write pending on node 5.
        @(negedge clk); drive(1'b1, 1'b1, 32'h80000000, 6'd0, 11'd5, 16'h0, 1'b0);
        @(negedge clk); drive(1'b1, 1'b1, 32'h80000000, 6'd0, 11'd5, 16'h0, 1'b0);
        @(posedge clk); #2;
        check("midrst_pre_valid", valid_o, 1'b1);
        rst_n = 1'b0;
        valid_i = 1'b0;
        wr_en_i = 1'b1; wr_addr_i = 11'd5; wr_data_i = mk_node(11'h007, 1, 1, 1, 16'hDEAD);
        #1;
        check("midrst_valid", valid_o, 1'b0);
        check("midrst_stat", stat_lookups_o, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1; wr_en_i = 1'b0;
        @(negedge clk); drive(1'b1, 1'b1, 32'h80000000, 6'd0, 11'd5, 16'h0, 1'b0);
        @(negedge clk); valid_i = 1'b0;
        @(posedge clk); #1;
        check("postrst_lookup", {valid_o, active_o, location_o, result_o, result_vld_o, bit_pos_o},
              {1'b1, 1'b0, 11'h000, 16'h0105, 1'b1, 6'd1});
        check("postrst_stat", stat_lookups_o, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
